// File: rtl/silife_vga_render_if.sv
// rtl/silife_vga_render_if.sv - cell-array fetch and video output bundle for silife_vga_render
interface silife_vga_render_if #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
);
    localparam int RW = $clog2(HEIGHT);

    // Cell array side: row request out, selected row back in
    logic [WIDTH-1:0] i_cells;
    logic [RW-1:0]    o_row_select;

    // Live display controls
    logic             i_grid_en;
    logic             i_invert;

    // Video side
    logic             o_hsync;
    logic             o_vsync;
    logic             o_data;
    logic             o_grid;
    logic             o_frame_end;

    // Renderer view
    modport master (
        input  i_cells,
        input  i_grid_en,
        input  i_invert,
        output o_row_select,
        output o_hsync,
        output o_vsync,
        output o_data,
        output o_grid,
        output o_frame_end
    );

    // Cell array / display consumer view
    modport slave (
        output i_cells,
        output i_grid_en,
        output i_invert,
        input  o_row_select,
        input  o_hsync,
        input  o_vsync,
        input  o_data,
        input  o_grid,
        input  o_frame_end
    );
endinterface

// File: rtl/silife_vga_render.sv
// rtl/silife_vga_render.sv - VGA timing and cell-grid renderer with one-row line buffer
module silife_vga_render #(
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int CELL_SHIFT = 3,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    silife_vga_render_if.master  vga
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW        = $clog2(H_TOTAL);
    localparam int YW        = $clog2(V_TOTAL);
    localparam int RW        = $clog2(HEIGHT);
    localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CELL_MASK = (1 << CELL_SHIFT) - 1;

    // Grid extent in pixels, clipped to the visible area
    localparam int GRID_W = ((WIDTH  << CELL_SHIFT) < H_ACTIVE) ? (WIDTH  << CELL_SHIFT) : H_ACTIVE;
    localparam int GRID_H = ((HEIGHT << CELL_SHIFT) < V_ACTIVE) ? (HEIGHT << CELL_SHIFT) : V_ACTIVE;

    localparam logic [XW-1:0] X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_FETCH   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_CAPTURE = XW'(H_ACTIVE + 1);
    localparam logic [XW-1:0] X_HS_BEG  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] X_GRID    = XW'(GRID_W);
    localparam logic [XW-1:0] X_MASK    = XW'(CELL_MASK);

    localparam logic [YW-1:0] Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VS_BEG  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] Y_GRID    = YW'(GRID_H);
    localparam logic [YW-1:0] Y_MASK    = YW'(CELL_MASK);
    localparam logic [YW-1:0] Y_FRAME   = YW'(V_ACTIVE);

    // Parameter sanity: the grid must fit the visible area and the row index needs >= 1 bit
    generate
        if ((WIDTH << CELL_SHIFT) > H_ACTIVE) begin : g_chk_width
            $error("silife_vga_render: WIDTH<<CELL_SHIFT exceeds H_ACTIVE");
        end
        if ((HEIGHT << CELL_SHIFT) > V_ACTIVE) begin : g_chk_height
            $error("silife_vga_render: HEIGHT<<CELL_SHIFT exceeds V_ACTIVE");
        end
        if (HEIGHT < 2) begin : g_chk_rows
            $error("silife_vga_render: HEIGHT must be at least 2");
        end
    endgenerate

    // Beam position of the pixel being computed this cycle
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;

    // Row fetch state and the one-row line buffer
    logic [RW-1:0]    r_row_sel;
    logic             r_fetch_pend;
    logic [WIDTH-1:0] r_buf;

    logic             w_x_last;
    logic             w_y_last;
    logic [YW-1:0]    w_next_y;
    logic [RW-1:0]    w_next_row;
    logic             w_next_fetch;
    logic             w_in_grid;
    logic [CW-1:0]    w_col;
    logic             w_cell;
    logic             w_cell_edge;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_frame_end;

    assign w_x_last     = (r_x == X_LAST);
    assign w_y_last     = (r_y == Y_LAST);
    // Line after this one, wrapping so row 0 is prefetched during the last line of a frame
    assign w_next_y     = w_y_last ? '0 : (r_y + 1'b1);
    assign w_next_row   = RW'(w_next_y >> CELL_SHIFT);
    // Only the first line of each cell row inside the grid needs a new row from the array
    assign w_next_fetch = (w_next_y < Y_GRID) && ((w_next_y & Y_MASK) == '0);

    assign w_in_grid    = (r_x < X_GRID) && (r_y < Y_GRID);
    assign w_col        = CW'(r_x >> CELL_SHIFT);
    assign w_cell       = r_buf[w_col];
    assign w_cell_edge  = ((r_x & X_MASK) == '0) || ((r_y & Y_MASK) == '0);

    assign w_hsync_n    = !((r_x >= X_HS_BEG) && (r_x < X_HS_END));
    assign w_vsync_n    = !((r_y >= Y_VS_BEG) && (r_y < Y_VS_END));
    assign w_frame_end  = (r_x == '0) && (r_y == Y_FRAME);

    // Row select leaves the block directly from its register so the array sees it early
    assign vga.o_row_select = r_row_sel;

    // Raster counters: x runs along the line, y advances when x wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_last) begin
            r_x <= '0;
            r_y <= w_next_y;
        end else begin
            r_x <= r_x + 1'b1;
        end
    end

    // Request the next cell row at the end of active video, capture it one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_sel    <= '0;
            r_fetch_pend <= 1'b0;
            r_buf        <= '0;
        end else if ((r_x == X_FETCH) && w_next_fetch) begin
            r_row_sel    <= w_next_row;
            r_fetch_pend <= 1'b1;
        end else if ((r_x == X_CAPTURE) && r_fetch_pend) begin
            r_buf        <= vga.i_cells;
            r_fetch_pend <= 1'b0;
        end
    end

    // Video outputs: all registered once so sync, pixels and frame pulse stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            vga.o_hsync     <= 1'b1;
            vga.o_vsync     <= 1'b1;
            vga.o_data      <= 1'b0;
            vga.o_grid      <= 1'b0;
            vga.o_frame_end <= 1'b0;
        end else begin
            vga.o_hsync     <= w_hsync_n;
            vga.o_vsync     <= w_vsync_n;
            vga.o_data      <= w_in_grid && (w_cell ^ vga.i_invert);
            vga.o_grid      <= w_in_grid && vga.i_grid_en && w_cell_edge;
            vga.o_frame_end <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_silife_vga_render.sv
// tb/tb_silife_vga_render.sv - self-checking bench for silife_vga_render
module tb_silife_vga_render;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int CS     = 2;
    localparam int CELL   = 1 << CS;
    localparam int HA = 40, HF = 4, HS = 6, HB = 5;
    localparam int VA = 20, VF = 2, VS = 3, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int GW = (WIDTH * CELL < HA) ? WIDTH * CELL : HA;
    localparam int GH = (HEIGHT * CELL < VA) ? HEIGHT * CELL : VA;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    silife_vga_render_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) vif ();

    silife_vga_render #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CELL_SHIFT(CS),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif)
    );

    // Cell array model: answers the requested row combinationally
    logic [WIDTH-1:0] cells_mem [HEIGHT];
    always_comb vif.i_cells = cells_mem[vif.o_row_select];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: next pixel to display, line buffer, expected row select
    int               mx, my, lx, ly, cyc;
    logic [WIDTH-1:0] mbuf;
    logic [1:0]       mrow;
    bit               mpend;

    typedef struct {
        bit ge; bit inv; int x; int y;
        bit hs; bit vs; bit d; bit g;
    } vec_t;
    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (pixel x=%0d y=%0d)", name, act, exp, lx, ly);
        end
    endtask

    // One pixel clock: predict outputs for (mx,my), clock, compare
    task automatic step();
        bit   in_grid;
        logic e_hs, e_vs, e_d, e_g, e_fe;
        int   ny;
        in_grid = (mx < GW) && (my < GH);
        e_hs    = !((mx >= HA + HF) && (mx < HA + HF + HS));
        e_vs    = !((my >= VA + VF) && (my < VA + VF + VS));
        e_d     = in_grid ? (mbuf[mx / CELL] ^ vif.i_invert) : 1'b0;
        e_g     = vif.i_grid_en && in_grid && ((mx % CELL == 0) || (my % CELL == 0));
        e_fe    = (mx == 0) && (my == VA);
        ny      = (my + 1) % VT;
        if (mx == HA + 1 && mpend) begin
            mbuf  = cells_mem[mrow];
            mpend = 0;
        end
        if (mx == HA && ny < GH && (ny % CELL) == 0) begin
            mrow  = 2'(ny / CELL);
            mpend = 1;
        end
        lx = mx; ly = my;
        @(posedge clk); #1;
        cyc++;
        check("pix", {vif.o_hsync, vif.o_vsync, vif.o_data, vif.o_grid, vif.o_frame_end, vif.o_row_select},
                     {e_hs, e_vs, e_d, e_g, e_fe, mrow});
        mx++;
        if (mx == HT) begin
            mx = 0;
            my = (my + 1) % VT;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        check("reset_vals", {vif.o_hsync, vif.o_vsync, vif.o_data, vif.o_grid, vif.o_frame_end, vif.o_row_select},
                            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        reset = 1'b0;
        mx = 0; my = 0; mbuf = '0; mrow = '0; mpend = 0; cyc = 0;
    endtask

    task automatic goto(input int x, input int y);
        int guard = 0;
        while (!(mx == x && my == y) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("goto_reached", {31'd0, (mx == x && my == y)}, 32'd1);
    endtask

    task automatic pix_at(input int x, input int y, input string name, input logic exp_d);
        goto(x, y);
        step();
        check(name, {31'd0, vif.o_data}, {31'd0, exp_d});
    endtask

    task automatic measure_timing();
        int hs_first = -1, hs_second = -1, hs_low = 0;
        int vs_first = -1, vs_low = 0;
        int fe_n = 0, fe_first = -1, fe_second = -1;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        repeat (2 * FRAME) begin
            step();
            if (!vif.o_hsync) hs_low++;
            if (!vif.o_vsync) vs_low++;
            if (prev_hs && !vif.o_hsync) begin
                if (hs_first < 0) hs_first = cyc;
                else if (hs_second < 0) hs_second = cyc;
            end
            if (prev_vs && !vif.o_vsync && vs_first < 0) vs_first = cyc;
            if (vif.o_frame_end) begin
                fe_n++;
                if (fe_first < 0) fe_first = cyc;
                else if (fe_second < 0) fe_second = cyc;
            end
            prev_hs = vif.o_hsync;
            prev_vs = vif.o_vsync;
        end
        check("hs_first_fall", hs_first, HA + HF + 1);
        check("hs_period", hs_second - hs_first, HT);
        check("hs_low_total", hs_low, 2 * VT * HS);
        check("vs_first_fall", vs_first, (VA + VF) * HT + 1);
        check("vs_low_total", vs_low, 2 * VS * HT);
        check("fe_count", fe_n, 2);
        check("fe_first", fe_first, VA * HT + 1);
        check("fe_period", fe_second - fe_first, FRAME);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 1,  0,  0, 1, 1, 1, 1};
        vecs[1]  = '{1, 0, 32,  0, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 43,  1, 1, 1, 0, 0};
        vecs[3]  = '{0, 0, 44,  1, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 49,  1, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 50,  1, 1, 1, 0, 0};
        vecs[6]  = '{1, 0,  4,  3, 1, 1, 0, 1};
        vecs[7]  = '{0, 0,  4,  4, 1, 1, 0, 0};
        vecs[8]  = '{1, 0,  5,  5, 1, 1, 0, 0};
        vecs[9]  = '{1, 1, 45,  5, 0, 1, 0, 0};
        vecs[10] = '{1, 0,  3,  8, 1, 1, 0, 1};
        vecs[11] = '{0, 1, 31, 15, 1, 1, 1, 0};
        vecs[12] = '{0, 1, 32, 15, 1, 1, 0, 0};
        vecs[13] = '{1, 0,  0, 16, 1, 1, 0, 0};
        vecs[14] = '{0, 1, 31, 16, 1, 1, 0, 0};
        vecs[15] = '{1, 1,  0, 20, 1, 1, 0, 0};
        vecs[16] = '{1, 1,  0, 22, 1, 0, 0, 0};
        vecs[17] = '{1, 1,  2, 24, 1, 0, 0, 0};
        vecs[18] = '{1, 1,  0, 25, 1, 1, 0, 0};

        for (int r = 0; r < HEIGHT; r++) cells_mem[r] = '0;
        vif.i_grid_en = 1'b1;
        vif.i_invert  = 1'b1;
        lx = 0; ly = 0;
        do_reset(3);

        // Sync and frame pulse positions from release, all cells dead
        vif.i_grid_en = 1'b0;
        vif.i_invert  = 1'b0;
        measure_timing();

        // Fixed pixel vectors, all cells dead
        for (int i = 0; i < 19; i++) begin
            vif.i_grid_en = vecs[i].ge;
            vif.i_invert  = vecs[i].inv;
            goto(vecs[i].x, vecs[i].y);
            step();
            check("vec", {vif.o_hsync, vif.o_vsync, vif.o_data, vif.o_grid},
                         {vecs[i].hs, vecs[i].vs, vecs[i].d, vecs[i].g});
        end

        // Row prefetch and line buffer contents
        vif.i_grid_en = 1'b0;
        vif.i_invert  = 1'b0;
        cells_mem[0] = 8'h3C;
        cells_mem[1] = 8'hA5;
        cells_mem[2] = 8'h0F;
        cells_mem[3] = 8'hF0;
        goto(HA, 3);
        check("rowsel_before_fetch", vif.o_row_select, 0);
        step();
        check("rowsel_row1", vif.o_row_select, 1);
        pix_at(0,  4, "row1_col0", 1'b1);
        pix_at(4,  4, "row1_col1", 1'b0);
        pix_at(8,  4, "row1_col2", 1'b1);
        pix_at(28, 4, "row1_col7", 1'b1);
        pix_at(32, 4, "row1_outside", 1'b0);
        goto(HA, VT - 1);
        check("rowsel_before_wrap", vif.o_row_select, 3);
        step();
        check("rowsel_wrap_row0", vif.o_row_select, 0);
        pix_at(0, 1, "row0_col0", 1'b0);
        pix_at(8, 1, "row0_col2", 1'b1);

        // Randomised controls and cell contents
        repeat (8 * FRAME) begin
            vif.i_grid_en = 1'($urandom);
            vif.i_invert  = 1'($urandom);
            if ($urandom_range(63) == 0) cells_mem[$urandom_range(HEIGHT - 1)] = WIDTH'($urandom);
            step();
        end

        // Reset in the middle of a line, then timing must restart cleanly
        vif.i_grid_en = 1'b1;
        vif.i_invert  = 1'b1;
        goto(30, 10);
        do_reset(1);
        vif.i_grid_en = 1'b0;
        vif.i_invert  = 1'b0;
        measure_timing();

        repeat (2 * FRAME) begin
            vif.i_grid_en = 1'($urandom);
            vif.i_invert  = 1'($urandom);
            if ($urandom_range(31) == 0) cells_mem[$urandom_range(HEIGHT - 1)] = WIDTH'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/silife_vga_render.md
SILIFE_VGA_RENDER -- requirements
Module: silife_vga_render

Interface
REQ-001 Parameter WIDTH, default 32: grid columns, i.e. cells per row.
REQ-002 Parameter HEIGHT, default 32: grid rows.
REQ-003 Parameter CELL_SHIFT, default 3: log2 of the cell edge in pixels (3 = 8x8).
REQ-004 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixel clocks.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-006 clk  input  1  pixel clock; the block has one clock only.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 i_cells  input  WIDTH  cell states of the selected row; bit n = column n, 1 = alive.
REQ-009 i_grid_en  input  1  enables grid-line overlay.
REQ-010 i_invert  input  1  inverts the cell colour inside the grid area.
REQ-011 o_hsync  output  1  horizontal sync, active low.
REQ-012 o_vsync  output  1  vertical sync, active low.
REQ-013 o_data  output  1  cell pixel.
REQ-014 o_grid  output  1  grid-line pixel.
REQ-015 o_row_select  output  $clog2(HEIGHT)  row index requested from the cell array.
REQ-016 o_frame_end  output  1  one-clock pulse at the start of vertical blanking.

Function
REQ-017 The block SHALL use counters x in 0..H_TOTAL-1 and y in 0..V_TOTAL-1, where H_TOTAL = sum of the H params and V_TOTAL = sum of the V params; x wraps to 0 and increments y; y wraps to 0 after V_TOTAL-1.
REQ-018 Sync SHALL be asserted low for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-019 Grid area SHALL be x < WIDTH<<CELL_SHIFT and y < HEIGHT<<CELL_SHIFT, further clipped to x < H_ACTIVE and y < V_ACTIVE.
REQ-020 All outputs except o_row_select SHALL be registered with exactly 1 clock of latency from the (x,y) they describe, so sync, data, grid and frame_end stay mutually aligned.
REQ-021 Row prefetch: at x == H_ACTIVE of line y, with ny = (y+1) mod V_TOTAL, if ny is in the grid area and ny[CELL_SHIFT-1:0] == 0, o_row_select SHALL update to ny>>CELL_SHIFT on the next edge.
REQ-022 The line buffer SHALL capture i_cells on the edge ending cycle x == H_ACTIVE+1 of the same line; i_cells must be valid within 1 clock of an o_row_select change.
REQ-023 o_row_select SHALL hold its value at all other times; no fetch occurs for lines outside the grid area.
REQ-024 o_data SHALL equal buf[x>>CELL_SHIFT] XOR i_invert inside the grid area, and 0 outside it, including during blanking.
REQ-025 o_grid SHALL be 1 iff i_grid_en=1, (x,y) is in the grid area, and x[CELL_SHIFT-1:0]==0 or y[CELL_SHIFT-1:0]==0; o_grid is independent of o_data.
REQ-026 o_frame_end SHALL be 1 for the single output cycle corresponding to x==0, y==V_ACTIVE.
REQ-027 Row 0 for every frame SHALL be fetched during line V_TOTAL-1 of the previous frame (wrap case of REQ-021).
REQ-028 i_grid_en and i_invert SHALL be sampled every clock with no internal latching.
REQ-029 The block SHALL contain elaboration checks that WIDTH<<CELL_SHIFT <= H_ACTIVE, HEIGHT<<CELL_SHIFT <= V_ACTIVE, and HEIGHT >= 2.

Reset
REQ-030 While reset=1: x=0, y=0, o_hsync=1, o_vsync=1, o_data=0, o_grid=0, o_frame_end=0, o_row_select=0, line buffer cleared.
REQ-031 Reset asserted mid-line or mid-frame SHALL abort any fetch; the first frame after reset displays row 0 as all-dead (zero buffer, XOR i_invert) until the first wrap fetch.

Verification
REQ-032 Defaults, reset released: o_hsync low for exactly 96 clocks starting 657 clocks after release, period 800; o_vsync low for 1600 clocks, frame period 420000 clocks.
REQ-033 Cell model drives pattern 32'hA5A5_0F0F for row 1 -> o_row_select becomes 1 one clock after x=640 of line 7; line 8 pixels x=0..255 match the pattern bit-per-8-pixels, and x>=256 gives o_data=0.
REQ-034 i_grid_en=1, all cells dead -> o_grid=1 at (8,3) and (3,16); 0 at (9,9); 0 at (256,0) and (0,256).
REQ-035 i_invert=1, all cells dead -> o_data=1 for x<256, y<256; 0 elsewhere and in blanking.
REQ-036 o_frame_end pulses exactly once per frame, aligned with output of (0,480); row 0 is refetched at x=640 of line 524.
REQ-037 Reset pulsed at line 100, x=300 -> all outputs take their reset values next edge; timing restarts from (0,0) with correct sync positions.
